// File: rtl/counter_pkg.sv
// Shared constants and direction type for counter blocks.
package counter_pkg;

  localparam int DEF_WIDTH   = 3;
  localparam int DEF_MODULUS = 8;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/updown_counter_if.sv
// Control/status bundle for updown_counter.
// Carries Gray output g when GRAY_OUT_EN is defined.
interface updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
`ifdef GRAY_OUT_EN
  logic [WIDTH-1:0] g;
`endif

  modport master (
    output en, up, load, din,
    input  q, tc, wrap
`ifdef GRAY_OUT_EN
    , input g
`endif
  );

  modport slave (
    input  en, up, load, din,
    output q, tc, wrap
`ifdef GRAY_OUT_EN
    , output g
`endif
  );

endinterface

// File: rtl/jk_ff_sync.sv
// JK flip-flop with synchronous active-high clear.
module jk_ff_sync (
  input  logic clk,
  input  logic clear,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qb
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00:   q <= q;
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  assign qb = ~q;

endmodule

// File: rtl/updown_counter.sv
// Modulo up/down counter on JK state bits with load and wrap pulse.
// Optional Gray output g enabled by GRAY_OUT_EN (needs MODULUS == 2**WIDTH).
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic        clk,
  input  logic        clear,
  updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] cu;
  logic [WIDTH-1:0] cd;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] ld;
  logic [WIDTH-1:0] wv;
  logic [WIDTH-1:0] nq;
  dir_e             dir;
  logic             at_max;
  logic             at_zero;
  logic             tc;
  logic             s_clr;
  logic             s_ld;
  logic             s_wr;
  logic             s_cnt;
  logic             wrap_q;

  assign dir     = dir_e'(bus.up);
  assign at_max  = (q == MAXV);
  assign at_zero = &qb;

  assign tc = bus.en & ~bus.load &
              (((dir == DIR_UP) & at_max) |
               ((dir == DIR_DOWN) & at_zero));

  assign ld = (bus.din > MAXV) ? MAXV : bus.din;
  assign wv = (dir == DIR_UP) ? '0 : MAXV;

  // Toggle chains: bit i flips when all lower bits are 1 (up) or 0 (down)
  assign cu[0] = 1'b1;
  assign cd[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign cu[i] = cu[i-1] & q[i-1];
    assign cd[i] = cd[i-1] & qb[i-1];
  end

  assign t = (cu & {WIDTH{bus.up}}) |
             (cd & {WIDTH{~bus.up}});

  assign s_clr = clear;
  assign s_ld  = ~clear & bus.load;
  assign s_wr  = ~clear & tc;
  assign s_cnt = ~clear & ~bus.load & bus.en & ~tc;

  always_comb begin
    j = '0;
    k = '0;
    unique case (1'b1)
      s_clr: begin
        j = '0;
        k = '1;
      end
      s_ld: begin
        j = ld;
        k = ~ld;
      end
      s_wr: begin
        j = wv;
        k = ~wv;
      end
      s_cnt: begin
        j = t;
        k = t;
      end
      default: begin
        j = '0;
        k = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_sync u_ff (
      .clk   (clk),
      .clear (clear),
      .j     (j[i]),
      .k     (k[i]),
      .q     (q[i]),
      .qb    (qb[i])
    );
  end

  assign nq = (j & qb) | (~k & q);

  always_ff @(posedge clk) begin
    if (clear) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= s_wr;
    end
  end

`ifdef GRAY_OUT_EN
  logic [WIDTH-1:0] g_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      g_q <= '0;
    end else begin
      g_q <= nq ^ (nq >> 1);
    end
  end

  assign bus.g = g_q;
`else
  logic unused_nq;
  assign unused_nq = ^nq;
`endif

  assign bus.q    = q;
  assign bus.tc   = tc;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter (MODULUS 8 and 6 instances).
module tb_updown_counter;

  logic clk;
  logic clear;
  int   vectors;
  int   miscompares;

  updown_counter_if #(.WIDTH(3)) b8 ();
  updown_counter_if #(.WIDTH(3)) b6 ();

  updown_counter #(.WIDTH(3), .MODULUS(8)) u8 (
    .clk   (clk),
    .clear (clear),
    .bus   (b8)
  );

  updown_counter #(.WIDTH(3), .MODULUS(6)) u6 (
    .clk   (clk),
    .clear (clear),
    .bus   (b6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    b8.load = 1'b1; b8.din = 3'd5; b8.en = 1'b1; b8.up = 1'b1;
    b6.load = 1'b1; b6.din = 3'd5; b6.en = 1'b1; b6.up = 1'b1;
    tick();
    tick();
    vectors++;
    if (b8.q !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_q8 got %0d want 0", b8.q);
    end
    vectors++;
    if (b8.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_wrap8 got %0b want 0", b8.wrap);
    end
    vectors++;
    if (b8.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tc8 got %0b want 0", b8.tc);
    end
    vectors++;
    if (b6.q !== 3'd0 || b6.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_m6 got q=%0d wrap=%0b want 0/0", b6.q, b6.wrap);
    end
    clear = 1'b0;
    b8.load = 1'b0; b8.en = 1'b0;
    b6.load = 1'b0; b6.en = 1'b0;
    #1;
  endtask

  task automatic test_up_wrap;
    int exp = 0;
    b8.en = 1'b1; b8.up = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      vectors++;
      if (b8.tc !== (exp == 7)) begin
        miscompares++;
        $display("FAIL up_tc q=%0d got %0b want %0b", exp, b8.tc, exp == 7);
      end
      tick();
      exp = (exp + 1) % 8;
      vectors++;
      if (b8.q !== 3'(exp)) begin
        miscompares++;
        $display("FAIL up_q step %0d got %0d want %0d", i, b8.q, exp);
      end
      vectors++;
      if (b8.wrap !== (i == 8)) begin
        miscompares++;
        $display("FAIL up_wrap step %0d got %0b want %0b", i, b8.wrap, i == 8);
      end
    end
    b8.en = 1'b0;
  endtask

  task automatic test_down_wrap;
    int seq[6] = '{5, 4, 3, 2, 1, 0};
    int exp = 0;
    b6.en = 1'b1; b6.up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (b6.tc !== (exp == 0)) begin
        miscompares++;
        $display("FAIL dn_tc q=%0d got %0b want %0b", exp, b6.tc, exp == 0);
      end
      tick();
      exp = seq[i];
      vectors++;
      if (b6.q !== 3'(exp) || b6.wrap !== (i == 0)) begin
        miscompares++;
        $display("FAIL dn_step %0d got q=%0d wrap=%0b want q=%0d wrap=%0b",
                 i, b6.q, b6.wrap, exp, i == 0);
      end
    end
    b6.en = 1'b0;
  endtask

  task automatic test_load_sat;
    b6.load = 1'b1; b6.din = 3'd7; b6.en = 1'b1; b6.up = 1'b1;
    #1;
    vectors++;
    if (b6.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL load_tc got %0b want 0", b6.tc);
    end
    tick();
    vectors++;
    if (b6.q !== 3'd5 || b6.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL load_sat got q=%0d wrap=%0b want 5/0", b6.q, b6.wrap);
    end
    b6.din = 3'd3;
    tick();
    vectors++;
    if (b6.q !== 3'd3) begin
      miscompares++;
      $display("FAIL load_3 got %0d want 3", b6.q);
    end
    b6.load = 1'b0;
  endtask

  task automatic test_dir_flip;
    b6.en = 1'b1; b6.up = 1'b1;
    tick();
    vectors++;
    if (b6.q !== 3'd4) begin
      miscompares++;
      $display("FAIL flip_up got %0d want 4", b6.q);
    end
    b6.up = 1'b0;
    tick();
    vectors++;
    if (b6.q !== 3'd3 || b6.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL flip_dn got q=%0d wrap=%0b want 3/0", b6.q, b6.wrap);
    end
    b6.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (b6.q !== 3'd3 || b6.tc !== 1'b0 || b6.wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL hold %0d got q=%0d tc=%0b wrap=%0b want 3/0/0",
                 i, b6.q, b6.tc, b6.wrap);
      end
    end
  endtask

  task automatic test_clear_priority;
    b8.load = 1'b1; b8.din = 3'd7; b8.en = 1'b0;
    tick();
    vectors++;
    if (b8.q !== 3'd7) begin
      miscompares++;
      $display("FAIL clr_pre got %0d want 7", b8.q);
    end
    b8.load = 1'b0; b8.en = 1'b1; b8.up = 1'b1;
    #1;
    vectors++;
    if (b8.tc !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_tc got %0b want 1", b8.tc);
    end
    clear = 1'b1;
    tick();
    vectors++;
    if (b8.q !== 3'd0 || b8.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_wrap got q=%0d wrap=%0b want 0/0", b8.q, b8.wrap);
    end
    b8.load = 1'b1; b8.din = 3'd4;
    tick();
    vectors++;
    if (b8.q !== 3'd0) begin
      miscompares++;
      $display("FAIL clr_load got %0d want 0", b8.q);
    end
    clear = 1'b0;
    b8.load = 1'b0; b8.en = 1'b0;
    #1;
  endtask

`ifdef GRAY_OUT_EN
  task automatic test_gray;
    logic [2:0] gexp[8] = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
    logic [2:0] prev;
    vectors++;
    if (b8.g !== 3'd0) begin
      miscompares++;
      $display("FAIL gray_reset got %0d want 0", b8.g);
    end
    prev = 3'd0;
    b8.en = 1'b1; b8.up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (b8.g !== gexp[i] || $countones(b8.g ^ prev) != 1) begin
        miscompares++;
        $display("FAIL gray step %0d got %0d want %0d", i, b8.g, gexp[i]);
      end
      prev = b8.g;
    end
    b8.en = 1'b0;
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    clear = 1'b0;
    b8.en = 1'b0; b8.up = 1'b1; b8.load = 1'b0; b8.din = '0;
    b6.en = 1'b0; b6.up = 1'b1; b6.load = 1'b0; b6.din = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_sat();
    test_dir_flip();
    test_clear_priority();
`ifdef GRAY_OUT_EN
    test_gray();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 Parameter WIDTH, default 3, count register width in bits.
REQ-002 Parameter MODULUS, default 8, count states 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port clear  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  count enable.
REQ-006 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 Port load  input  1  parallel-load strobe.
REQ-008 Port din  input  WIDTH  parallel-load value.
REQ-009 Port q  output  WIDTH  current count, registered.
REQ-010 Port tc  output  1  terminal count, combinational.
REQ-011 Port wrap  output  1  registered one-cycle pulse marking that the last edge wrapped.

Function
REQ-012 Edge priority: clear > load > en; with none of them asserted, q holds.
REQ-013 load=1: q <= din when din < MODULUS, else q <= MODULUS-1 (saturate); wrap <= 0; en and up ignored.
REQ-014 en=1, up=1, load=0: q <= q+1 when q < MODULUS-1; at q = MODULUS-1, q <= 0 and wrap <= 1.
REQ-015 en=1, up=0, load=0: q <= q-1 when q > 0; at q = 0, q <= MODULUS-1 and wrap <= 1.
REQ-016 wrap is 0 on every edge that is not a wrap edge, including hold edges.
REQ-017 tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)); combinational, same cycle as the edge that wraps.
REQ-018 Direction may change on any cycle with no dead cycle; the next edge uses the new up value.
REQ-019 Latency: load, count, and clear each take effect on q one edge after being sampled.
REQ-020 State bits are built from JK flip-flops (J=K=toggle for counting); next-state logic is gate-level toggle equations derived from q, up, en; load and clear drive J/K directly (J=d, K=~d).
REQ-021 No arithmetic overflow beyond WIDTH; all comparisons are against MODULUS-1 held as a WIDTH-bit constant.

Reset
REQ-022 clear=1 at an edge: q <= 0, wrap <= 0, regardless of en, load, up.
REQ-023 clear asserted mid-count takes priority over a simultaneous load or wrap edge; no wrap pulse is issued.
REQ-024 tc is purely combinational and follows q and inputs after reset; no asynchronous path exists.

Configuration
REQ-025 Macro GRAY_OUT_EN: when defined, an extra output port g (WIDTH bits, registered) is present and carries the binary-reflected Gray code of the next q, updated on the same edge as q; reset value is 0.
REQ-026 Without GRAY_OUT_EN, port g and its register are absent; all other behaviour is identical.
REQ-027 With GRAY_OUT_EN, MODULUS must equal 2**WIDTH (single-bit change on wrap); other values are illegal configurations.

Structure
REQ-028 Package counter_pkg holds the default WIDTH and MODULUS constants, and a direction typedef (DIR_DOWN=0, DIR_UP=1) shared with future counter blocks.
REQ-029 One sub-module, jk_ff_sync (ports q, qb, j, k, clk, clear; synchronous clear to q=0), is instantiated WIDTH times.
REQ-030 Toggle, load, and compare logic sits in updown_counter; the RTL targets 120-400 lines in total.

Verification
REQ-031 Reset: clear=1 for 2 cycles with load=1, din=5 -> q=0, wrap=0, tc=0 (up=1).
REQ-032 Up wrap (WIDTH=3, MODULUS=8): en=1, up=1 from q=0 for 8 edges -> q = 1..7,0; tc=1 only while q=7; wrap=1 only after the 8th edge.
REQ-033 Down wrap (MODULUS=6): en=1, up=0 from q=0 -> tc=1 at q=0; next q=5, wrap=1; then 4,3,2,1,0.
REQ-034 Load saturation (MODULUS=6): load=1, din=7, en=1 -> q=5, wrap=0; load=1, din=3 -> q=3.
REQ-035 Direction flip: q=3, up=1 one edge -> q=4; up=0 next edge -> q=3; en=0 three edges -> q stays 3, tc=0.
REQ-036 GRAY_OUT_EN (WIDTH=3): count up 0..7 -> g = 0,1,3,2,6,7,5,4; exactly one bit changes per edge, including 7->0.
